// File: rtl/sd_pkg.sv
// sd_pkg: sequencer states and register-block byte addresses shared by the SD command master.
package sd_pkg;
    typedef enum logic [2:0] {IDLE, WR_CMD, WR_ARG, POLL, RD_RESP, CLR_ISR, DONE} state_t;
    localparam logic [6:0] ADDR_ARG  = 7'h00;
    localparam logic [6:0] ADDR_CMD  = 7'h04;
    localparam logic [6:0] ADDR_RESP = 7'h08;
    localparam logic [6:0] ADDR_ISR  = 7'h34;
endpackage

// File: rtl/sd_bus_access.sv
// sd_bus_access: runs one registered byte read or write on the register-block port, holding writes WE_HOLD cycles.
module sd_bus_access #(
    parameter int WE_HOLD = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       wr,
    input  logic [6:0] addr,
    input  logic [7:0] wdata,
    output logic       op_done,
    output logic [7:0] rdata,
    output logic       bus_we,
    output logic [6:0] bus_addr,
    output logic [7:0] bus_wdata,
    input  logic [7:0] bus_rdata
);
    logic        active;
    logic [15:0] cnt;

    // op_done marks the last cycle of the current access so the next one can start on the same edge
    assign op_done = active && (!bus_we || cnt == 16'(WE_HOLD - 1));
    assign rdata   = bus_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            active    <= 1'b0;
            cnt       <= 16'd0;
            bus_we    <= 1'b0;
            bus_addr  <= 7'd0;
            bus_wdata <= 8'd0;
        end else if (start) begin
            active    <= 1'b1;
            cnt       <= 16'd0;
            bus_we    <= wr;
            bus_addr  <= addr;
            bus_wdata <= wr ? wdata : 8'd0;
        end else if (op_done) begin
            active    <= 1'b0;
            bus_we    <= 1'b0;
            bus_wdata <= 8'd0;
        end else if (active) begin
            cnt <= cnt + 16'd1;
        end
    end
endmodule

// File: rtl/sd_cmd_master.sv
// sd_cmd_master: turns one SD command request into the register-block byte sequence
// (command, argument, status poll, response read, status clear).
module sd_cmd_master import sd_pkg::*; #(
    parameter int WE_HOLD  = 1,
    parameter int POLL_MAX = 65535,
    parameter int CMD_W    = 14
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [CMD_W-1:0] req_cmd,
    input  logic [31:0]      req_arg,
    input  logic             req_long,
    output logic             done,
    output logic [4:0]       status,
    output logic             timeout,
    output logic [127:0]     resp,
    output logic             busy,
    output logic             bus_we,
    output logic [6:0]       bus_addr,
    output logic [7:0]       bus_wdata,
    input  logic [7:0]       bus_rdata
);
    state_t      state, state_n;
    logic [3:0]  idx, idx_n, nidx;
    logic [15:0] poll, cmd, cmd_in;
    logic [31:0] arg;
    logic        long_r, start, wr, op_done, hit, expire, last;
    logic [6:0]  addr;
    logic [7:0]  wdata, rdata;

    assign cmd_in = 16'(req_cmd);
    assign nidx   = idx + 4'd1;
    assign hit    = rdata[4:0] != 5'd0;
    assign expire = (poll + 16'd1) == 16'(POLL_MAX);
    assign last   = idx == (long_r ? 4'd15 : 4'd3);

    sd_bus_access #(.WE_HOLD(WE_HOLD)) u_bus (
        .clk(clk), .rst(rst), .start(start), .wr(wr), .addr(addr), .wdata(wdata),
        .op_done(op_done), .rdata(rdata),
        .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata)
    );

    // each state issues the next access on the edge that ends the current one
    always_comb begin
        state_n = state;
        idx_n   = idx;
        start   = 1'b0;
        wr      = 1'b0;
        addr    = ADDR_ISR;
        wdata   = 8'h00;
        case (state)
            IDLE: if (req_valid) begin
                state_n = WR_CMD;
                idx_n   = 4'd0;
                start   = 1'b1;
                wr      = 1'b1;
                addr    = ADDR_CMD;
                wdata   = cmd_in[7:0];
            end
            WR_CMD: if (op_done) begin
                start   = 1'b1;
                wr      = 1'b1;
                state_n = idx[0] ? WR_ARG : WR_CMD;
                idx_n   = idx[0] ? 4'd0 : 4'd1;
                addr    = idx[0] ? ADDR_ARG : ADDR_CMD + 7'd1;
                wdata   = idx[0] ? arg[7:0] : cmd[15:8];
            end
            WR_ARG: if (op_done) begin
                start   = 1'b1;
                wr      = idx != 4'd3;
                state_n = wr ? WR_ARG : POLL;
                idx_n   = nidx;
                addr    = wr ? ADDR_ARG + 7'(nidx) : ADDR_ISR;
                wdata   = wr ? arg[{nidx[1:0], 3'b000} +: 8] : 8'h00;
            end
            POLL: begin
                start   = 1'b1;
                wr      = !hit && expire;
                state_n = hit ? RD_RESP : expire ? CLR_ISR : POLL;
                idx_n   = 4'd0;
                addr    = hit ? ADDR_RESP : ADDR_ISR;
            end
            RD_RESP: begin
                start   = 1'b1;
                wr      = last;
                state_n = last ? CLR_ISR : RD_RESP;
                idx_n   = nidx;
                addr    = last ? ADDR_ISR : ADDR_RESP + 7'(nidx);
            end
            CLR_ISR: state_n = op_done ? DONE : CLR_ISR;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= 4'd0;
            poll      <= 16'd0;
            cmd       <= 16'd0;
            arg       <= 32'd0;
            long_r    <= 1'b0;
            status    <= 5'd0;
            timeout   <= 1'b0;
            resp      <= '0;
            done      <= 1'b0;
            busy      <= 1'b0;
            req_ready <= 1'b1;
        end else begin
            state     <= state_n;
            idx       <= idx_n;
            poll      <= state == POLL ? poll + 16'd1 : 16'd0;
            done      <= state_n == DONE;
            busy      <= state_n != IDLE;
            req_ready <= state_n == IDLE;
            if (state == IDLE && req_valid) begin
                cmd     <= cmd_in;
                arg     <= req_arg;
                long_r  <= req_long;
                status  <= 5'd0;
                timeout <= 1'b0;
                resp    <= '0;
            end
            if (state == POLL && hit) status <= rdata[4:0];
            if (state == POLL && !hit && expire) timeout <= 1'b1;
            if (state == RD_RESP) resp[{idx, 3'b000} +: 8] <= rdata;
        end
    end
endmodule

// File: tb/tb_sd_cmd_master.sv
// tb_sd_cmd_master: randomized commands on two instances (WE_HOLD 1 and 3) against a register-block
// model and an expected per-cycle bus trace.
module tb_sd_cmd_master;
    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [1:0]        req_valid = '0;
    logic [1:0]        req_long = '0;
    logic [1:0][13:0]  req_cmd = '0;
    logic [1:0][31:0]  req_arg = '0;
    logic [1:0]        req_ready, done, timeout, busy, bus_we;
    logic [1:0][4:0]   status;
    logic [1:0][127:0] resp;
    logic [1:0][6:0]   bus_addr;
    logic [1:0][7:0]   bus_wdata, bus_rdata;
    logic [7:0]        rmem [2][16];
    logic [7:0]        isr_val [2];
    int                isr_at [2];
    int                isr_cnt [2];
    logic [15:0]       tr [2][$];
    logic [15:0]       ex [$];
    int                checks = 0;
    int                failures = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : u
        sd_cmd_master #(.WE_HOLD(g == 0 ? 1 : 3), .POLL_MAX(8), .CMD_W(14)) dut (
            .clk(clk), .rst(rst), .req_valid(req_valid[g]), .req_ready(req_ready[g]),
            .req_cmd(req_cmd[g]), .req_arg(req_arg[g]), .req_long(req_long[g]),
            .done(done[g]), .status(status[g]), .timeout(timeout[g]), .resp(resp[g]), .busy(busy[g]),
            .bus_we(bus_we[g]), .bus_addr(bus_addr[g]), .bus_wdata(bus_wdata[g]), .bus_rdata(bus_rdata[g])
        );
    end

    // register block: cmd_isr reads zero until read number isr_at, response bytes from rmem
    always_comb
        for (int k = 0; k < 2; k++)
            bus_rdata[k] = bus_addr[k] == 7'h34 ? ((isr_cnt[k] + 1 >= isr_at[k]) ? isr_val[k] : 8'h00)
                         : (bus_addr[k] >= 7'h08 && bus_addr[k] <= 7'h17) ? rmem[k][4'(bus_addr[k] - 7'h08)] : 8'h00;

    always @(posedge clk)
        for (int k = 0; k < 2; k++)
            if (req_valid[k] && req_ready[k]) isr_cnt[k] <= 0;
            else if (busy[k] && !bus_we[k] && !done[k] && bus_addr[k] == 7'h34) isr_cnt[k] <= isr_cnt[k] + 1;

    always begin
        @(negedge clk);
        #2;
        for (int k = 0; k < 2; k++)
            if (busy[k] && !done[k]) tr[k].push_back({bus_we[k], bus_addr[k], bus_wdata[k]});
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push(input int h, input logic we, input logic [6:0] ad, input logic [7:0] d);
        repeat (h) ex.push_back({we, ad, d});
    endtask

    function automatic logic [7:0] rv();
        return {3'($urandom), 5'($urandom_range(1, 31))};
    endfunction

    task automatic run(input int k, input logic [13:0] c, input logic [31:0] a, input logic l,
                       input int at, input logic [7:0] v, input bit hold);
        int h, n, p, nr, lat;
        bit to;
        logic [15:0] c16;
        logic [127:0] er;
        h = k == 0 ? 1 : 3;
        for (int i = 0; i < 16; i++) rmem[k][i] = 8'($urandom);
        isr_at[k] = at;
        isr_val[k] = v;
        to = at > 8;
        p = to ? 8 : at;
        nr = to ? 0 : (l ? 16 : 4);
        c16 = 16'(c);
        er = '0;
        ex.delete();
        push(h, 1'b1, 7'h04, c16[7:0]);
        push(h, 1'b1, 7'h05, c16[15:8]);
        for (int i = 0; i < 4; i++) push(h, 1'b1, 7'(i), a[8*i +: 8]);
        for (int i = 0; i < p; i++) push(1, 1'b0, 7'h34, 8'h00);
        for (int i = 0; i < nr; i++) begin
            push(1, 1'b0, 7'(8 + i), 8'h00);
            er[8*i +: 8] = rmem[k][i];
        end
        push(h, 1'b1, 7'h34, 8'h00);
        lat = 7 * h + p + nr + 1;
        @(negedge clk);
        tr[k].delete();
        req_valid[k] = 1'b1;
        req_cmd[k] = c;
        req_arg[k] = a;
        req_long[k] = l;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (!hold) req_valid[k] = 1'b0;
            else begin
                req_cmd[k] = 14'($urandom);
                req_arg[k] = $urandom;
                req_long[k] = 1'($urandom);
            end
        end while (!done[k] && n < 400);
        check($sformatf("latency%0d", k), 128'(n), 128'(lat));
        check("status", 128'(status[k]), to ? 128'd0 : 128'(v[4:0]));
        check("timeout", 128'(timeout[k]), 128'(to));
        check("resp", resp[k], er);
        check("trace_len", 128'(tr[k].size()), 128'(ex.size()));
        foreach (ex[i]) if (i < tr[k].size()) check($sformatf("bus%0d", i), 128'(tr[k][i]), 128'(ex[i]));
        if (!hold) begin
            @(negedge clk);
            check("done_pulse", 128'(done[k]), 128'd0);
            check("idle_ready", 128'({busy[k], req_ready[k]}), 128'd1);
        end
    endtask

    initial begin
        int n;
        for (int k = 0; k < 2; k++) begin
            isr_at[k] = 0;
            isr_val[k] = 8'h00;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check("rst_ctrl", 128'({req_ready[k], busy[k], done[k], timeout[k]}), 128'b1000);
            check("rst_status", 128'(status[k]), 128'd0);
            check("rst_resp", resp[k], 128'd0);
            check("rst_bus", 128'({bus_we[k], bus_addr[k], bus_wdata[k]}), 128'd0);
        end
        rst = 1'b0;
        run(0, 14'h0119, 32'hDEADBEEF, 1'b0, 3, 8'h01, 1'b0);
        run(0, 14'($urandom), $urandom, 1'b1, $urandom_range(1, 6), rv(), 1'b0);
        run(0, 14'($urandom), $urandom, 1'b1, 100, rv(), 1'b0);
        run(1, 14'($urandom), $urandom, 1'b0, 2, rv(), 1'b0);
        run(1, 14'($urandom), $urandom, 1'b1, 1, rv(), 1'b0);
        run(1, 14'($urandom), $urandom, 1'b0, 100, rv(), 1'b0);
        for (int i = 0; i < 6; i++)
            run(i % 2, 14'($urandom), $urandom, 1'($urandom), $urandom_range(1, 10), rv(), 1'b0);
        run(0, 14'($urandom), $urandom, 1'b1, 2, rv(), 1'b1);
        @(negedge clk);
        check("b2b_accept", 128'({req_ready[0], busy[0]}), 128'b10);
        @(negedge clk);
        req_valid[0] = 1'b0;
        check("b2b_resp_clr", resp[0], 128'd0);
        check("b2b_busy", 128'(busy[0]), 128'd1);
        n = 0;
        while (!done[0] && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("b2b_done", 128'(done[0]), 128'd1);
        @(negedge clk);
        tr[0].delete();
        isr_at[0] = 1;
        req_valid[0] = 1'b1;
        req_cmd[0] = 14'h1234;
        req_arg[0] = 32'h01020304;
        req_long[0] = 1'b0;
        @(negedge clk);
        req_valid[0] = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_mid_pre", 128'({bus_we[0], bus_addr[0], bus_wdata[0]}), 128'({1'b1, 7'h01, 8'h03}));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_state", 128'({bus_we[0], busy[0], req_ready[0]}), 128'b001);
        repeat (10) @(negedge clk);
        check("rst_mid_trace", 128'(tr[0].size()), 128'd4);
        check("rst_mid_we", 128'(bus_we[0]), 128'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
